// File: rtl/stream_argext_if.sv
// Stream bundle for stream_argext: input word stream, packet mode and
// result channel. The slave modport is the reducer's view.
`default_nettype none

interface stream_argext_if #(
  parameter int WIDTH     = 32,
  parameter int IDX_WIDTH = 16
);
  logic                 is_signed;
  logic                 find_min;
  logic                 s_valid;
  logic                 s_ready;
  logic [WIDTH-1:0]     s_data;
  logic                 s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [WIDTH-1:0]     m_value;
  logic [IDX_WIDTH-1:0] m_index;
  logic [IDX_WIDTH-1:0] m_count;
  logic                 m_ovf;

  modport slave (
    input  is_signed, find_min, s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_value, m_index, m_count, m_ovf
  );

  modport master (
    output is_signed, find_min, s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_value, m_index, m_count, m_ovf
  );
endinterface

`default_nettype wire

// File: rtl/stream_argext.sv
//------------------------------------------------------------------------------
// Module  : stream_argext
// Brief   : Streaming arg-max/arg-min reducer over a valid/ready packet stream.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module stream_argext #(
  parameter int WIDTH     = 32,
  parameter int IDX_WIDTH = 16
) (
  input  logic            clk,
  input  logic            srstn,
  stream_argext_if.slave  bus
);

  localparam logic [1:0] ST_FIRST  = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_OUTPUT = 2'd2;

  localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);

  logic [1:0]           state_q, state_d;
  logic                 ready_q, ready_d;
  logic [WIDTH-1:0]     best_q, best_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 sgn_q, sgn_d;
  logic                 min_q, min_d;

  logic                 w_beat;
  logic [WIDTH-1:0]     w_sign_flip;
  logic [WIDTH-1:0]     w_new_key;
  logic [WIDTH-1:0]     w_best_key;
  logic                 w_better;

  assign w_beat = bus.s_valid & ready_q;

  // Flipping the MSB maps two's complement order onto unsigned order.
  assign w_sign_flip = {sgn_q, {(WIDTH-1){1'b0}}};
  assign w_new_key   = bus.s_data ^ w_sign_flip;
  assign w_best_key  = best_q ^ w_sign_flip;
  assign w_better    = min_q ? (w_new_key < w_best_key) : (w_new_key > w_best_key);

  always_comb begin
    state_d = state_q;
    best_d  = best_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    sgn_d   = sgn_q;
    min_d   = min_q;
    case (state_q)
      ST_FIRST: begin
        if (w_beat) begin
          best_d  = bus.s_data;
          idx_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          sgn_d   = bus.is_signed;
          min_d   = bus.find_min;
          state_d = bus.s_last ? ST_OUTPUT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_beat) begin
          cnt_d = cnt_q + IDX_ONE;
          if (&cnt_q) begin
            ovf_d = 1'b1;
          end
          if (w_better) begin
            best_d = bus.s_data;
            idx_d  = cnt_q + IDX_ONE;
          end
          state_d = bus.s_last ? ST_OUTPUT : ST_ACCUM;
        end
      end
      ST_OUTPUT: begin
        if (bus.m_ready) begin
          state_d = ST_FIRST;
        end
      end
      default: state_d = ST_FIRST;
    endcase
    // Registered ready follows the next state, so it never depends combinationally on inputs.
    ready_d = (state_d != ST_OUTPUT);
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q <= ST_FIRST;
      ready_q <= 1'b0;
      best_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      sgn_q   <= 1'b0;
      min_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      best_q  <= best_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      sgn_q   <= sgn_d;
      min_q   <= min_d;
    end
  end

  assign bus.s_ready = ready_q;
  assign bus.m_valid = (state_q == ST_OUTPUT);
  assign bus.m_value = best_q;
  assign bus.m_index = idx_q;
  assign bus.m_count = cnt_q;
  assign bus.m_ovf   = ovf_q;

endmodule

`default_nettype wire
